// File: rtl/riscv_pkg.sv
// riscv_pkg: shared definitions for the MEM-stage data memory.
//   - funct3 access-size constants
//   - memory FSM state enum
//   - latched request descriptor (size / sign / direction / byte offset)
//   - helpers that classify and decode a request from funct3 and addr[1:0]
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } mem_state_t;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } mem_size_t;

  typedef struct packed {
    logic      wr;    // store when set
    mem_size_t size;
    logic      sext;  // sign-extend on load
    logic [1:0] off;  // byte offset within the word
  } mem_req_t;

  // Legal funct3 for the direction, and natural alignment for the size.
  function automatic logic req_legal(input logic wr, input logic [2:0] f3,
                                     input logic [1:0] off);
    logic ok;
    case (f3)
      F3_B:    ok = 1'b1;
      F3_H:    ok = ~off[0];
      F3_W:    ok = (off == 2'b00);
      F3_BU:   ok = ~wr;
      F3_HU:   ok = ~wr & ~off[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic mem_req_t req_decode(input logic wr, input logic [2:0] f3,
                                          input logic [1:0] off);
    mem_req_t r;
    r.wr   = wr;
    r.off  = off;
    r.sext = (f3 == F3_B) || (f3 == F3_H);
    case (f3[1:0])
      2'b00:   r.size = SZ_B;
      2'b01:   r.size = SZ_H;
      default: r.size = SZ_W;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/data_mem_bank.sv
// data_mem_bank: single-port MEM_DEPTH x 32 word store.
//   clk    in   clock
//   en     in   access strobe for this cycle
//   we     in   write (1) / read (0) when en
//   be     in   byte enables for writes
//   idx    in   word index
//   wdata  in   write data, already lane-steered
//   rdata  out  registered read word (one cycle after a read strobe)
// Storage and the read register are intentionally not reset.
module data_mem_bank #(
  parameter int MEM_DEPTH = 1024
) (
  input  logic                         clk,
  input  logic                         en,
  input  logic                         we,
  input  logic [3:0]                   be,
  input  logic [$clog2(MEM_DEPTH)-1:0] idx,
  input  logic [31:0]                  wdata,
  output logic [31:0]                  rdata
);

  logic [3:0][7:0] mem [MEM_DEPTH];

  // All enabled lanes commit on the same edge.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int l = 0; l < 4; l++)
          if (be[l]) mem[idx][l] <= wdata[8*l +: 8];
      end else begin
        rdata <= mem[idx];
      end
    end
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: MEM-stage data-memory responder.
//   clk, rst_n         clock, async active-low reset
//   MemRead, MemWrite  load / store strobes (both high => store)
//   funct3             access size and signedness
//   addr               byte address; upper bits beyond the bank wrap
//   wdata              store data (low bytes used)
//   rdata              extended load data, non-zero only in RESP of a load
//   stall              holds the pipeline while an access is in flight
//   misaligned         request rejected (alignment or funct3), IDLE only
// Flow: IDLE -> ACCESS (WAIT_STATES extra cycles, bank strobed on the last)
//       -> RESP -> IDLE.
module data_mem_ctrl
  import riscv_pkg::*;
#(
  parameter int MEM_DEPTH   = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        misaligned
);

  localparam int         IDX_W = $clog2(MEM_DEPTH);
  localparam logic [3:0] WS    = 4'(WAIT_STATES);

  mem_state_t       state;
  logic [3:0]       cnt;
  mem_req_t         req_q;
  logic [IDX_W-1:0] idx_q;
  logic [31:0]      wdata_q;

  logic req, legal, accept;
  logic unused_addr;

  assign req    = MemRead | MemWrite;
  assign legal  = req_legal(MemWrite, funct3, addr[1:0]);
  assign accept = (state == ST_IDLE) & req & legal;
  assign unused_addr = ^addr[31:IDX_W+2];

  // Gated by rst_n so every output reads 0 while reset is held,
  // even if the pipeline keeps presenting a request.
  assign stall      = rst_n & (accept | (state == ST_ACCESS));
  assign misaligned = rst_n & (state == ST_IDLE) & req & ~legal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      req_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
    end else begin
      case (state)
        ST_IDLE: if (accept) begin
          state   <= ST_ACCESS;
          cnt     <= WS;
          req_q   <= req_decode(MemWrite, funct3, addr[1:0]);
          idx_q   <= addr[IDX_W+1:2];
          wdata_q <= wdata;
        end
        ST_ACCESS: begin
          if (cnt != '0) cnt   <= cnt - 4'd1;
          else           state <= ST_RESP;
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Bank is strobed only on the last ACCESS cycle; a reset before that
  // edge drops the store entirely.
  logic        bank_en, bank_we;
  logic [3:0]  be;
  logic [31:0] wlane, bank_rdata;

  assign bank_en = (state == ST_ACCESS) && (cnt == '0);
  assign bank_we = bank_en & req_q.wr;

  always_comb begin
    be    = 4'b1111;
    wlane = wdata_q;
    case (req_q.size)
      SZ_B: begin
        be    = 4'b0001 << req_q.off;
        wlane = {4{wdata_q[7:0]}};
      end
      SZ_H: begin
        be    = 4'b0011 << req_q.off;
        wlane = {2{wdata_q[15:0]}};
      end
      default: ;
    endcase
  end

  data_mem_bank #(.MEM_DEPTH(MEM_DEPTH)) u_bank (
    .clk   (clk),
    .en    (bank_en),
    .we    (bank_we),
    .be    (be),
    .idx   (idx_q),
    .wdata (wlane),
    .rdata (bank_rdata)
  );

  // Load extraction: shift the addressed lane down, then extend.
  logic [31:0] shifted, ext;

  always_comb begin
    shifted = bank_rdata >> {req_q.off, 3'b000};
    ext     = shifted;
    case (req_q.size)
      SZ_B: ext = {{24{req_q.sext & shifted[7]}},  shifted[7:0]};
      SZ_H: ext = {{16{req_q.sext & shifted[15]}}, shifted[15:0]};
      default: ;
    endcase
  end

  assign rdata = (state == ST_RESP && !req_q.wr) ? ext : '0;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Bench for data_mem_ctrl: three instances (WAIT_STATES 1, 0, 3) on a
// shared clock, each with its own inputs and reset. A vector table drives
// accesses through a scoreboard; hand sequences cover back-to-back timing
// and reset during a store.
module tb_data_mem_ctrl;
  import riscv_pkg::*;

  localparam int ND = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [ND-1:0]       rst_n;
  logic [ND-1:0]       mr, mw;
  logic [ND-1:0][2:0]  f3v;
  logic [ND-1:0][31:0] av, wv, rdata;
  logic [ND-1:0]       stall, mis;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    data_mem_ctrl #(
      .MEM_DEPTH   (1024),
      .WAIT_STATES ((g == 0) ? 1 : (g == 1) ? 0 : 3)
    ) dut (
      .clk        (clk),
      .rst_n      (rst_n[g]),
      .MemRead    (mr[g]),
      .MemWrite   (mw[g]),
      .funct3     (f3v[g]),
      .addr       (av[g]),
      .wdata      (wv[g]),
      .rdata      (rdata[g]),
      .stall      (stall[g]),
      .misaligned (mis[g])
    );
  end

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", nm, act, exp);
  endtask

  // One access: drive, then watch until RESP (or an immediate reject).
  // nst = stall cycles seen (for a reject: stall in that same cycle).
  task automatic access(input int d, input logic rd, input logic wr,
                        input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output int nst,
                        output logic [31:0] rdo, output logic misr,
                        output logic tmo, output int t_drv, output int t_resp);
    logic done;
    mr[d] = rd; mw[d] = wr; f3v[d] = f3; av[d] = a; wv[d] = wd;
    t_drv = cyc; t_resp = 0;
    nst = 0; rdo = '0; misr = 1'b0; done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (c == 0 && mis[d]) begin
        misr = 1'b1; nst = int'(stall[d]); rdo = rdata[d]; done = 1'b1;
      end else if (stall[d]) begin
        nst++;
      end else begin
        rdo = rdata[d]; t_resp = cyc; done = 1'b1;
      end
      @(posedge clk); #1;
    end
    mr[d] = 1'b0; mw[d] = 1'b0;
    tmo = !done;
  endtask

  typedef struct {
    string nm; int d; logic rd; logic wr; logic [2:0] f3;
    logic [31:0] a; logic [31:0] wd;
    logic [31:0] er; int es; logic em;
  } vec_t;

  typedef struct {
    string nm; logic [31:0] er; int es; logic em;
  } exp_t;

  vec_t vt[$];
  exp_t sb[$];

  function automatic void add(input string nm, input int d, input logic rd,
                              input logic wr, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] er, input int es, input logic em);
    vec_t v;
    v.nm = nm; v.d = d; v.rd = rd; v.wr = wr; v.f3 = f3; v.a = a; v.wd = wd;
    v.er = er; v.es = es; v.em = em;
    vt.push_back(v);
  endfunction

  initial begin
    int nst, t0, t1, t2, t3;
    logic [31:0] rdo;
    logic misr, tmo;
    exp_t e;

    rst_n = '0; mr = '0; mw = '0; f3v = '0; av = '0; wv = '0;

    // DUT 0: WAIT_STATES=1 -> 3 stall cycles; DUT 1: 0 -> 2; DUT 2: 3 -> 5
    add("sw 10",      0, 0, 1, F3_W,  32'h10, 32'hDEADBEEF, 32'h0,        3, 0);
    add("lw 10",      0, 1, 0, F3_W,  32'h10, 32'h0,        32'hDEADBEEF, 3, 0);
    add("sw 20",      0, 0, 1, F3_W,  32'h20, 32'h80FF7F01, 32'h0,        3, 0);
    add("lb 23",      0, 1, 0, F3_B,  32'h23, 32'h0,        32'hFFFFFF80, 3, 0);
    add("lbu 23",     0, 1, 0, F3_BU, 32'h23, 32'h0,        32'h00000080, 3, 0);
    add("lh 22",      0, 1, 0, F3_H,  32'h22, 32'h0,        32'hFFFF80FF, 3, 0);
    add("lhu 20",     0, 1, 0, F3_HU, 32'h20, 32'h0,        32'h00007F01, 3, 0);
    add("lb 20",      0, 1, 0, F3_B,  32'h20, 32'h0,        32'h00000001, 3, 0);
    add("sw 20 zero", 0, 0, 1, F3_W,  32'h20, 32'h0,        32'h0,        3, 0);
    add("sb 21",      0, 0, 1, F3_B,  32'h21, 32'h123456AA, 32'h0,        3, 0);
    add("sh 22",      0, 0, 1, F3_H,  32'h22, 32'hABCD1234, 32'h0,        3, 0);
    add("lw 20 sub",  0, 1, 0, F3_W,  32'h20, 32'h0,        32'h1234AA00, 3, 0);
    add("sw 30",      0, 0, 1, F3_W,  32'h30, 32'hCAFEF00D, 32'h0,        3, 0);
    add("lh 31 mis",  0, 1, 0, F3_H,  32'h31, 32'h0,        32'h0,        0, 1);
    add("sw 32 mis",  0, 0, 1, F3_W,  32'h32, 32'h11111111, 32'h0,        0, 1);
    add("st f3 100",  0, 0, 1, F3_BU, 32'h30, 32'h22222222, 32'h0,        0, 1);
    add("ld f3 011",  0, 1, 0, 3'b011,32'h30, 32'h0,        32'h0,        0, 1);
    add("lw 30 keep", 0, 1, 0, F3_W,  32'h30, 32'h0,        32'hCAFEF00D, 3, 0);
    add("rd+wr sw",   0, 1, 1, F3_W,  32'h40, 32'h55667788, 32'h0,        3, 0);
    add("lw 40",      0, 1, 0, F3_W,  32'h40, 32'h0,        32'h55667788, 3, 0);
    add("ws0 sw 0",   1, 0, 1, F3_W,  32'h0,  32'h0BADC0DE, 32'h0,        2, 0);
    add("ws0 lw 1000",1, 1, 0, F3_W,  32'h1000,32'h0,       32'h0BADC0DE, 2, 0);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("rst stall d%0d", d), 32'(stall[d]), 32'h0);
      chk($sformatf("rst mis d%0d", d),   32'(mis[d]),   32'h0);
      chk($sformatf("rst rdata d%0d", d), rdata[d],      32'h0);
    end
    @(posedge clk); #1;
    rst_n = '1;
    @(posedge clk); #1;

    // Table through the scoreboard
    foreach (vt[i]) begin
      sb.push_back('{vt[i].nm, vt[i].er, vt[i].es, vt[i].em});
      access(vt[i].d, vt[i].rd, vt[i].wr, vt[i].f3, vt[i].a, vt[i].wd,
             nst, rdo, misr, tmo, t0, t1);
      e = sb.pop_front();
      chk({e.nm, " timeout"}, 32'(tmo),  32'h0);
      chk({e.nm, " rdata"},   rdo,       e.er);
      chk({e.nm, " stall"},   32'(nst),  32'(e.es));
      chk({e.nm, " mis"},     32'(misr), 32'(e.em));
    end

    // Back-to-back with no wait states: second RESP 5 cycles after first issue
    access(1, 1, 0, F3_W, 32'h0, 32'h0, nst, rdo, misr, tmo, t0, t1);
    chk("b2b first rdata", rdo, 32'h0BADC0DE);
    access(1, 1, 0, F3_W, 32'h1000, 32'h0, nst, rdo, misr, tmo, t2, t3);
    chk("b2b second rdata", rdo, 32'h0BADC0DE);
    chk("b2b second stall", 32'(nst), 32'd2);
    chk("b2b no bubble", 32'(t2 - t1), 32'd1);
    chk("b2b resp2 cycle", 32'(t3 - t0), 32'd5);

    // Reset during the first ACCESS cycle of a store (WAIT_STATES=3)
    access(2, 0, 1, F3_W, 32'h50, 32'h01020304, nst, rdo, misr, tmo, t0, t1);
    chk("ws3 sw stall", 32'(nst), 32'd5);
    mw[2] = 1'b1; f3v[2] = F3_W; av[2] = 32'h50; wv[2] = 32'hFFFFFFFF;
    @(posedge clk); #1;
    chk("ws3 in access stall", 32'(stall[2]), 32'h1);
    rst_n[2] = 1'b0;
    #1;
    chk("midrst stall", 32'(stall[2]), 32'h0);
    chk("midrst mis",   32'(mis[2]),   32'h0);
    chk("midrst rdata", rdata[2],      32'h0);
    repeat (2) @(posedge clk);
    #1;
    mw[2] = 1'b0;
    rst_n[2] = 1'b1;
    @(posedge clk); #1;
    access(2, 1, 0, F3_W, 32'h50, 32'h0, nst, rdo, misr, tmo, t0, t1);
    chk("midrst old word", rdo, 32'h01020304);
    chk("midrst lw stall", 32'(nst), 32'd5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Data-memory responder for the MEM stage. Consumes the `MemRead`/`MemWrite` strobes produced by the main decoder, along with funct3, address and store data from the EX/MEM register. Performs byte/half/word loads and stores against an internal synchronous word-organised bank, with a configurable number of wait states. Holds the pipeline through `stall` until the access completes, and returns sign- or zero-extended load data.

## Interface
- `MEM_DEPTH`, 1024 — bank depth in 32-bit words; power of two.
- `WAIT_STATES`, 1 — extra access cycles per request; range 0–15.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `MemRead`  in  1  load request; held stable while `stall`=1.
- `MemWrite`  in  1  store request; held stable while `stall`=1.
- `funct3`  in  3  access size and signedness.
- `addr`  in  32  byte address (ALU result).
- `wdata`  in  32  store data (rs2); the low bytes are used.
- `rdata`  out  32  extended load data; valid only in RESP.
- `stall`  out  1  freezes PC and IF/ID/EX/MEM registers.
- `misaligned`  out  1  request rejected: bad alignment or illegal funct3.

## Operation
- Request: `req` = `MemRead` | `MemWrite`.
  - If both are high, the request is a store.
- funct3 decoding:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other code is illegal.
- Alignment:
  - Half access requires `addr[0]`=0.
  - Word access requires `addr[1:0]`=0.
- Word index = `addr[log2(MEM_DEPTH)+1:2]`. Upper address bits are ignored, so addresses wrap modulo the bank size.
- Store byte enables and lane placement:
  - SB: `be`=1<<`addr[1:0]`, with `wdata[7:0]` replicated to all lanes.
  - SH: `be`=3<<`addr[1:0]`, with `wdata[15:0]` replicated to both halves.
  - SW: `be`=4'b1111.
- Load extraction: the selected byte or half is taken from the bank word and shifted down. LB/LH sign-extend; LBU/LHU zero-extend.
- FSM states: IDLE, ACCESS, RESP.
  - IDLE → ACCESS when `req` is set, the access is legal and `misaligned`=0. The wait counter loads `WAIT_STATES`.
  - IDLE with an illegal request: state stays IDLE, `misaligned`=1 (combinational), `stall`=0, no bank write, `rdata`=0.
  - ACCESS, counter ≠ 0: the counter decrements.
  - ACCESS, counter = 0: the bank access is issued this cycle (write commits, or the read word is registered). The next state is RESP.
  - RESP → IDLE unconditionally. The pipeline advances at the end of RESP.
- `stall`:
  - IDLE: `stall`=`req` & legal (combinational).
  - ACCESS: 1.
  - RESP: 0.
- `rdata` is the extended bank output in RESP for a load, and 0 otherwise.

## Timing
- Request in IDLE at cycle 0:
  - `stall` is high for cycles 0 through `WAIT_STATES`+1.
  - RESP occurs at cycle `WAIT_STATES`+2, with `rdata` valid.
- A back-to-back request is accepted in the IDLE cycle that immediately follows RESP. No bubble is added beyond that cycle.
- The store commits at the clock edge that leaves ACCESS. That edge falls within the final `stall` cycle.
- Reset values: state=IDLE, counter=0, `stall`=0, `rdata`=0, `misaligned`=0. Bank contents are not reset.
- Reset asserted mid-operation returns the FSM to IDLE immediately.
  - A store is lost unless the committing edge has already occurred.
  - No partial write is permitted: all four byte lanes commit on the same edge.
- Input changes during `stall` are a protocol violation. The latched request controls the access.

## Structure
- Shared package `riscv_pkg` holds:
  - funct3 constants (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`);
  - the memory FSM state enum;
  - the `req` size/sign typedef.
- Sub-module `data_mem_bank` has:
  - `MEM_DEPTH`×32 storage, with a single port;
  - a 4-bit byte-enable write;
  - a registered 1-cycle read;
  - no reset on the storage.
- `data_mem_ctrl` contains the FSM, wait counter, request latch, byte-lane steering and load extension.

## Test plan
- **SW then LW:** `WAIT_STATES`=1. SW `wdata`=0xDEADBEEF to `addr`=0x10, then LW from 0x10.
  - `stall` is high for 3 cycles on each access.
  - `rdata`=0xDEADBEEF in RESP.
- **Sub-word loads:** with word 0x80FF7F01 at 0x20:
  - LB 0x23 → 0xFFFFFF80.
  - LBU 0x23 → 0x00000080.
  - LH 0x22 → 0xFFFF80FF.
  - LHU 0x20 → 0x00007F01.
- **Sub-word stores:** SB 0xAA to 0x21 and SH 0x1234 to 0x22 over 0x00000000.
  - A subsequent LW returns 0x1234AA00.
- **Misalignment:** LH 0x31, then SW 0x32.
  - `misaligned`=1 and `stall`=0 in the same cycle.
  - A follow-up LW 0x30 shows the original contents.
- **Zero wait states:** `WAIT_STATES`=0, two consecutive LW requests.
  - `stall` is high for 2 cycles per request.
  - Second RESP at cycle 5.
  - LW from 0x1000 with `MEM_DEPTH`=1024 aliases to 0x0000.
- **Reset mid-store:** `rst_n` pulled low during the first ACCESS cycle of an SW with `WAIT_STATES`=3.
  - All outputs go to 0 immediately.
  - A subsequent LW shows the old word.
